// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: shifter states and default sizing.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DEF_DIVISOR = 16;
  localparam int DEF_DEPTH   = 4;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, head visible combinationally on rdata; same-cycle wr+rd keeps fill.
// Writes while full and reads while empty are ignored; the caller flags dropped bytes.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [7:0]              wdata,
  input  logic                    rd,
  output logic [7:0]              rdata,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill;
  logic          w_do_wr;
  logic          w_do_rd;

  assign w_do_wr = wr && (r_fill < (AW+1)'(DEPTH));
  assign w_do_rd = rd && (r_fill != '0);

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_fill <= r_fill + (AW+1)'(1);
        2'b01:   r_fill <= r_fill - (AW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign fill  = r_fill;

endmodule

// File: rtl/serial_tx.sv
// 8N1 transmitter fed from a byte FIFO; txd goes low two cycles after a DataReady into an idle block.
// Credit flow control: DataNext is only raised when the FIFO can absorb every outstanding request.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DIVISOR = DEF_DIVISOR,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DataVal,
  input  logic       DataReady,
  output logic       DataNext,
  output logic       txd,
  output logic       busy,
  output logic       overflow
);

  localparam int CW = $clog2(DIVISOR);
  localparam int FW = $clog2(DEPTH) + 1;

  tx_state_t     r_state;
  tx_state_t     w_state_nxt;
  logic [CW-1:0] r_baud;
  logic [CW-1:0] w_baud_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_txd;
  logic          w_txd_nxt;
  logic          r_req_q;
  logic          r_overflow;
  logic [FW-1:0] w_fill;
  logic [7:0]    w_head;
  logic          w_pop;
  logic          w_bit_end;
  logic          w_fifo_full;
  logic          w_fifo_nonempty;
  logic [FW:0]   w_credit;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (DataReady),
    .wdata (DataVal),
    .rd    (w_pop),
    .rdata (w_head),
    .fill  (w_fill)
  );

  assign w_fifo_full     = (w_fill == FW'(DEPTH));
  assign w_fifo_nonempty = (w_fill != '0);

  // A request raised last cycle may still be answered this cycle, so count it as occupied.
  assign w_credit = {1'b0, w_fill} + {{FW{1'b0}}, r_req_q};
  assign DataNext = !rst && (w_credit < (FW+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_req_q <= DataNext;
      if (DataReady && w_fifo_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_bit_end = (r_baud == CW'(DIVISOR - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_txd_nxt   = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_baud_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (w_fifo_nonempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // txd is derived from the next state so the line flop changes together with the state.
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  assign txd      = r_txd;
  assign busy     = (r_state != IDLE) || w_fifo_nonempty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: line timing, producer-paced streams, credit limits, overflow and reset.
module tb_serial_tx;

  localparam int DIV  = 4;
  localparam int DEP  = 4;
  localparam int CHAR = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] DataVal;
  logic       DataReady;
  logic       DataNext;
  logic       txd;
  logic       busy;
  logic       overflow;

  serial_tx #(
    .DIVISOR (DIV),
    .DEPTH   (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .DataVal   (DataVal),
    .DataReady (DataReady),
    .DataNext  (DataNext),
    .txd       (txd),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] prod_q[$];
  logic [7:0] exp_q[$];
  logic       prod_en = 1'b0;
  logic       pend    = 1'b0;
  logic       rec_en  = 1'b0;
  logic       txq[$];
  logic       busyq[$];
  int         max_fill;
  int         dn_viol;
  int         dn_full_seen;
  logic       dn_prev;
  logic [7:0] rx_bytes[$];
  int         rx_pos[$];
  int         frame_err;
  logic [7:0] burst [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  // One cycle: producer answers last cycle's DataNext, monitor samples line and credit state.
  task automatic tick();
    int f;
    @(negedge clk);
    if (prod_en) begin
      if (pend && prod_q.size() > 0) begin
        DataReady = 1'b1;
        DataVal   = prod_q.pop_front();
      end else begin
        DataReady = 1'b0;
      end
      pend = DataNext;
    end
    if (rec_en) begin
      txq.push_back(txd);
      busyq.push_back(busy);
      f = int'(dut.u_fifo.fill);
      if (f > max_fill) max_fill = f;
      if (DataNext && (f + int'(dn_prev) >= DEP)) dn_viol++;
      if (!DataNext && (f + int'(dn_prev) < DEP)) dn_viol++;
      if (f + int'(dn_prev) == DEP) dn_full_seen++;
      dn_prev = DataNext;
    end
  endtask

  task automatic start_rec();
    txq.delete();
    busyq.delete();
    max_fill     = 0;
    dn_viol      = 0;
    dn_full_seen = 0;
    dn_prev      = DataNext;
    rec_en       = 1'b1;
  endtask

  // Reference 8N1 receiver: samples mid-bit from the first cycle of each start bit.
  task automatic decode();
    int i = 0;
    logic [7:0] b;
    rx_bytes.delete();
    rx_pos.delete();
    frame_err = 0;
    while (i + CHAR <= txq.size()) begin
      if (txq[i] == 1'b0) begin
        if (txq[i + DIV/2] != 1'b0) frame_err++;
        for (int j = 0; j < 8; j++) b[j] = txq[i + DIV*(j+1) + DIV/2];
        if (txq[i + 9*DIV + DIV/2] != 1'b1) frame_err++;
        rx_bytes.push_back(b);
        rx_pos.push_back(i);
        i += CHAR;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       exp_bit;
    int         k;
    int         p;
    int         guard;
    int         zeros;

    rst       = 1'b1;
    DataReady = 1'b0;
    DataVal   = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_datanext", DataNext, 0);
    rst = 1'b0;
    #1;
    check_eq("rel_datanext", DataNext, 1);

    // Single byte 0xA5: exact per-cycle waveform.
    tick();
    DataReady = 1'b1;
    DataVal   = 8'hA5;
    check_eq("a5_t_txd", txd, 1);
    tick();
    DataReady = 1'b0;
    check_eq("a5_t1_txd", txd, 1);
    check_eq("a5_t1_busy", busy, 1);
    b = 8'hA5;
    for (int i = 0; i < CHAR; i++) begin
      tick();
      k = i / DIV;
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = b[k-1];
      check_eq($sformatf("a5_cyc%0d", i), txd, exp_bit);
    end
    check_eq("a5_busy_last", busy, 1);
    tick();
    check_eq("a5_busy_fall", busy, 0);
    check_eq("a5_txd_idle", txd, 1);

    // Unanswered requests: credit released every cycle, nothing enters the FIFO.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("noreply_dn%0d", i), DataNext, 1);
      check_eq($sformatf("noreply_txd%0d", i), txd, 1);
    end
    check_eq("noreply_busy", busy, 0);

    // Sync pattern then 16 frame bytes, producer paced by DataNext.
    prod_q.delete();
    prod_q.push_back(8'hFF);
    prod_q.push_back(8'hFF);
    prod_q.push_back(8'hFF);
    prod_q.push_back(8'h7F);
    for (int i = 0; i < 16; i++) prod_q.push_back(8'(i * 29 + 5));
    exp_q = prod_q;
    start_rec();
    pend    = 1'b0;
    prod_en = 1'b1;
    repeat (CHAR * 20 + 50) tick();
    prod_en   = 1'b0;
    DataReady = 1'b0;
    decode();
    check_eq("frame_count", rx_bytes.size(), 20);
    check_eq("frame_err", frame_err, 0);
    for (int i = 0; i < 20 && i < rx_bytes.size(); i++) begin
      check_eq($sformatf("frame_byte%0d", i), rx_bytes[i], exp_q[i]);
      if (i > 0) check_eq($sformatf("frame_gap%0d", i), rx_pos[i] - rx_pos[i-1], CHAR);
    end
    p = (rx_pos.size() > 0) ? rx_pos[0] : 0;
    check_eq("frame_busy_end_m1", (p + 200*DIV - 1 < busyq.size()) ? busyq[p + 200*DIV - 1] : 1'b0, 1);
    check_eq("frame_busy_end", (p + 200*DIV < busyq.size()) ? busyq[p + 200*DIV] : 1'b1, 0);
    check_eq("frame_overflow", overflow, 0);

    // 1000 random bytes, producer answers every request.
    prod_q.delete();
    for (int i = 0; i < 1000; i++) prod_q.push_back(8'($urandom_range(0, 255)));
    exp_q = prod_q;
    start_rec();
    pend    = 1'b0;
    prod_en = 1'b1;
    guard   = 0;
    do begin
      tick();
      guard++;
    end while (!(prod_q.size() == 0 && !DataReady && !busy) && guard < 45000);
    prod_en   = 1'b0;
    DataReady = 1'b0;
    check_eq("rand_timeout", guard < 45000, 1);
    decode();
    check_eq("rand_count", rx_bytes.size(), 1000);
    check_eq("rand_frame_err", frame_err, 0);
    for (int i = 0; i < 1000 && i < rx_bytes.size(); i++) begin
      check_eq($sformatf("rand_byte%0d", i), rx_bytes[i], exp_q[i]);
    end
    check_eq("rand_max_fill", max_fill, DEP);
    check_eq("rand_credit_viol", dn_viol, 0);
    check_eq("rand_credit_full_seen", dn_full_seen > 0, 1);
    check_eq("rand_overflow", overflow, 0);

    // Forced burst of 5 while the shifter is busy: 5th byte dropped, overflow sticks.
    tick();
    DataReady = 1'b1;
    DataVal   = 8'h3C;
    start_rec();
    tick();
    DataReady = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) check_eq("ovf_before5", overflow, 0);
      DataReady = 1'b1;
      DataVal   = burst[i];
    end
    tick();
    DataReady = 1'b0;
    check_eq("ovf_set", overflow, 1);
    guard = 0;
    while (busy && guard < 400) begin
      tick();
      guard++;
    end
    check_eq("ovf_drain_timeout", guard < 400, 1);
    check_eq("ovf_sticky", overflow, 1);
    decode();
    check_eq("ovf_count", rx_bytes.size(), 5);
    check_eq("ovf_b0", (rx_bytes.size() > 0) ? rx_bytes[0] : 8'h00, 8'h3C);
    for (int i = 1; i < 5 && i < rx_bytes.size(); i++) begin
      check_eq($sformatf("ovf_b%0d", i), rx_bytes[i], burst[i-1]);
    end

    // Reset during data bit 3 with two bytes queued.
    rec_en = 1'b0;
    tick();
    DataReady = 1'b1;
    DataVal   = 8'h96;
    tick();
    DataReady = 1'b0;
    tick();
    tick();
    DataReady = 1'b1;
    DataVal   = 8'h5A;
    tick();
    DataVal   = 8'hC3;
    tick();
    DataReady = 1'b0;
    repeat (14) tick();
    check_eq("rstmid_pre_txd", txd, 0);
    check_eq("rstmid_pre_busy", busy, 1);
    check_eq("rstmid_pre_ovf", overflow, 1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_txd", txd, 1);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_dn", DataNext, 0);
    check_eq("rstmid_ovf", overflow, 0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rstmid_rel_dn", DataNext, 1);
    start_rec();
    repeat (100) tick();
    zeros = 0;
    foreach (txq[i]) if (txq[i] == 1'b0) zeros++;
    check_eq("rstmid_no_chars", zeros, 0);
    check_eq("rstmid_busy_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
